// File: rtl/tone_mixer.sv
// Multi-channel phase-accumulator tone generator, time-multiplexed mixer to one 8-bit sample.
// Optional sine ROM for mode 3 enabled by defining TONE_MIXER_SINE_EN (otherwise mode 3 = triangle).
`timescale 1ns/1ps
module tone_mixer #(
  parameter int CHANNELS   = 4,
  parameter int PHASE_BITS = 24
) (
  input  logic                  inputClock,
  input  logic                  reset,
  input  logic                  sampleStrobe,
  input  logic                  cfgWrite,
  input  logic [3:0]            cfgChannel,
  input  logic [PHASE_BITS-1:0] cfgFreq,
  input  logic [7:0]            cfgVolume,
  input  logic [1:0]            cfgMode,
  input  logic                  cfgEnable,
  input  logic                  cfgPhaseReset,
  output logic [7:0]            outputSample,
  output logic                  outputValid,
  output logic                  busy,
  output logic [7:0]            overrunCount
);
  localparam int LOG2_CH = $clog2(CHANNELS);
  localparam int KW      = (CHANNELS > 1) ? LOG2_CH : 1;
  localparam int SUM_W   = 8 + LOG2_CH;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                state;
  logic [KW-1:0]         k;
  logic [SUM_W-1:0]      sum;

  logic [PHASE_BITS-1:0] sh_freq  [CHANNELS];
  logic [7:0]            sh_vol   [CHANNELS];
  logic [1:0]            sh_mode  [CHANNELS];
  logic                  sh_en    [CHANNELS];
  logic                  sh_prst  [CHANNELS];
  logic [PHASE_BITS-1:0] act_freq [CHANNELS];
  logic [7:0]            act_vol  [CHANNELS];
  logic [1:0]            act_mode [CHANNELS];
  logic                  act_en   [CHANNELS];
  logic [PHASE_BITS-1:0] phase    [CHANNELS];
  logic                  wr_hit   [CHANNELS];

  logic [7:0]  p, tri_w, wave, scaled;
  logic [15:0] prod;
  logic [16:0] num;

`ifdef TONE_MIXER_SINE_EN
  // Quarter-wave magnitude round(127*sin(2*pi*i/256)), i = 0..63; i = 64 handled as 127.
  localparam logic [6:0] QSIN [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };

  function automatic logic [7:0] sine_lookup(input logic [7:0] ph);
    logic [6:0] mag;
    if (ph[6] && (ph[5:0] == 6'd0))
      mag = 7'd127;
    else if (ph[6])
      mag = QSIN[6'(7'd64 - {1'b0, ph[5:0]})];
    else
      mag = QSIN[ph[5:0]];
    return ph[7] ? (8'd128 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
  endfunction
`endif

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++)
      wr_hit[i] = cfgWrite && (32'(cfgChannel) == i);
  end

  always_comb begin
    p     = phase[k][PHASE_BITS-1 -: 8];
    tri_w = p[7] ? {~p[6:0], 1'b0} : {p[6:0], 1'b0};
    unique case (act_mode[k])
      2'd0:    wave = p;
      2'd1:    wave = p[7] ? 8'hFF : 8'h00;
      2'd2:    wave = tri_w;
`ifdef TONE_MIXER_SINE_EN
      default: wave = sine_lookup(p);
`else
      default: wave = tri_w;
`endif
    endcase
    prod   = wave * act_vol[k];
    num    = {1'b0, prod} + 17'd127;
    scaled = 8'(num / 17'd255);
  end

  always_ff @(posedge inputClock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      sum          <= '0;
      outputSample <= '0;
      outputValid  <= 1'b0;
      busy         <= 1'b0;
      overrunCount <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        sh_freq[i]  <= '0;
        sh_vol[i]   <= '0;
        sh_mode[i]  <= '0;
        sh_en[i]    <= 1'b0;
        sh_prst[i]  <= 1'b0;
        act_freq[i] <= '0;
        act_vol[i]  <= '0;
        act_mode[i] <= '0;
        act_en[i]   <= 1'b0;
        phase[i]    <= '0;
      end
    end else begin
      outputValid <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (wr_hit[i]) begin
          sh_freq[i] <= cfgFreq;
          sh_vol[i]  <= cfgVolume;
          sh_mode[i] <= cfgMode;
          sh_en[i]   <= cfgEnable;
          sh_prst[i] <= cfgPhaseReset;
        end
      end
      if (sampleStrobe && (state != IDLE) && (overrunCount != 8'hFF))
        overrunCount <= overrunCount + 8'd1;
      unique case (state)
        IDLE: begin
          if (sampleStrobe) begin
            // Same-edge writes bypass the shadow straight into the active set; pending flag is consumed here.
            for (int unsigned i = 0; i < CHANNELS; i++) begin
              act_freq[i] <= wr_hit[i] ? cfgFreq   : sh_freq[i];
              act_vol[i]  <= wr_hit[i] ? cfgVolume : sh_vol[i];
              act_mode[i] <= wr_hit[i] ? cfgMode   : sh_mode[i];
              act_en[i]   <= wr_hit[i] ? cfgEnable : sh_en[i];
              if (wr_hit[i] ? cfgPhaseReset : sh_prst[i])
                phase[i] <= '0;
              sh_prst[i] <= 1'b0;
            end
            k     <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (act_en[k]) begin
            sum      <= sum + SUM_W'(scaled);
            phase[k] <= phase[k] + act_freq[k];
          end
          if (k == KW'(CHANNELS - 1))
            state <= DONE;
          else
            k <= k + 1'b1;
        end
        DONE: begin
          outputSample <= 8'(sum >> LOG2_CH);
          outputValid  <= 1'b1;
          sum          <= '0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
